// File: rtl/bluetooth_tx.sv
// bluetooth_tx: bus-mapped UART transmitter feeding an HC-05 module through a small byte FIFO.
// Define BT_TX_PARITY_EN for an even-parity bit (8E1); otherwise frames are 8N1.
module bluetooth_tx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [3:0]  strb,
  input  logic [2:0]  addr,
  input  logic [31:0] data_i,
  output logic        ready,
  output logic [31:0] data_o,
  output logic        hc05_tx
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

`ifdef BT_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state_reg;
  logic [BW-1:0]   baud_reg;
  logic [2:0]      bit_idx_reg;
  logic [7:0]      shift_reg;
  logic            tx_reg;
  logic            ready_reg;
  logic            ready_next;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            ovf_reg;
`ifdef BT_TX_PARITY_EN
  logic            parity_reg;
`endif

  logic        bus_cycle, wr_data, wr_status, rd_status;
  logic        fifo_empty, fifo_full, bit_end, push, pop;
  logic [31:0] status_word;

  // Only the low byte and the OVF-clear bit of the write data have a destination.
  logic unused_wdata;
  assign unused_wdata = ^{data_i[31:8], data_i[7:4], data_i[2:0]};

  assign ready_next = valid & ~ready_reg;
  assign bus_cycle  = ready_reg & valid;
  assign wr_data    = bus_cycle & strb[0] & (addr == 3'h0);
  assign wr_status  = bus_cycle & strb[0] & (addr == 3'h4);
  assign rd_status  = bus_cycle & (strb == 4'b0000) & (addr == 3'h4);

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == DEPTH_C);
  assign bit_end    = (baud_reg == BAUD_LAST);
  // The head is taken either from idle or at the very end of a stop bit, so frames chain without a gap.
  assign pop  = ~fifo_empty & ((state_reg == IDLE) | ((state_reg == STOP) & bit_end));
  assign push = wr_data & (~fifo_full | pop);

  assign status_word = {24'h0, 4'(count_reg), ovf_reg, fifo_empty, fifo_full, (state_reg != IDLE)};
  assign data_o  = rd_status ? status_word : 32'h0;
  assign ready   = ready_reg;
  assign hc05_tx = tx_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_reg <= 1'b0;
    end else begin
      ready_reg <= ready_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= data_i[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + CW'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CW'(1);
      end
      if (wr_data && fifo_full && !pop) begin
        ovf_reg <= 1'b1;
      end else if (wr_status && data_i[3]) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
`ifdef BT_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (pop) begin
            shift_reg <= mem[rd_ptr_reg];
            state_reg <= START;
            tx_reg    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            state_reg   <= DATA;
            tx_reg      <= shift_reg[0];
`ifdef BT_TX_PARITY_EN
            parity_reg  <= shift_reg[0];
`endif
          end else begin
            baud_reg <= baud_reg + BW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_reg  <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_idx_reg == 3'd7) begin
`ifdef BT_TX_PARITY_EN
              state_reg <= PARITY;
              tx_reg    <= parity_reg;
`else
              state_reg <= STOP;
              tx_reg    <= 1'b1;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              tx_reg      <= shift_reg[1];
`ifdef BT_TX_PARITY_EN
              parity_reg  <= parity_reg ^ shift_reg[1];
`endif
            end
          end else begin
            baud_reg <= baud_reg + BW'(1);
          end
        end
`ifdef BT_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud_reg  <= '0;
            state_reg <= STOP;
            tx_reg    <= 1'b1;
          end else begin
            baud_reg <= baud_reg + BW'(1);
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            baud_reg <= '0;
            if (pop) begin
              shift_reg <= mem[rd_ptr_reg];
              state_reg <= START;
              tx_reg    <= 1'b0;
            end else begin
              state_reg <= IDLE;
              tx_reg    <= 1'b1;
            end
          end else begin
            baud_reg <= baud_reg + BW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          baud_reg  <= '0;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bluetooth_tx.sv
// Directed self-checking bench for bluetooth_tx at DIV=10, FIFO_DEPTH=4.
// Frame length follows BT_TX_PARITY_EN (10 or 11 bit periods).
module tb_bluetooth_tx;

  localparam int CLK_FREQ   = 1000000;
  localparam int BAUD       = 100000;
  localparam int DIV        = 10;
  localparam int FIFO_DEPTH = 4;
`ifdef BT_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [3:0]  strb = 4'h0;
  logic [2:0]  addr = 3'h0;
  logic [31:0] data_i = 32'h0;
  logic        ready;
  logic [31:0] data_o;
  logic        hc05_tx;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] ovf_frames [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h77};

  bluetooth_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .valid  (valid),
    .strb   (strb),
    .addr   (addr),
    .data_i (data_i),
    .ready  (ready),
    .data_o (data_o),
    .hc05_tx(hc05_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One bus request; returns read data and the cycle number in which ready was high.
  task automatic bus_xfer(input logic [2:0] a, input logic [3:0] s, input logic [31:0] d,
                          output logic [31:0] rd, output int rcyc);
    int n;
    valid = 1'b1; addr = a; strb = s; data_i = d;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ack_latency", n, 32'd1);
    rd = data_o;
    rcyc = cyc;
    @(posedge clk); #1;
    valid = 1'b0; strb = 4'h0; data_i = 32'h0;
    check("ack_pulse", {31'b0, ready}, 32'd0);
    $display("bus %s addr=%0h strb=%0h wdata=%08h rdata=%08h ack_cycle=%0d",
             (s == 4'h0) ? "rd" : "wr", a, s, d, rd, rcyc);
  endtask

  // Called in the first cycle of the start bit; checks every cycle of one frame.
  task automatic check_frame(input logic [7:0] b, input string tag);
    logic [NBITS-1:0] bits;
    bits[0]   = 1'b0;
    bits[8:1] = b;
`ifdef BT_TX_PARITY_EN
    bits[9]   = ^b;
`endif
    bits[NBITS-1] = 1'b1;
    for (int k = 0; k < NBITS; k++) begin
      for (int c = 0; c < DIV; c++) begin
        check(tag, {31'b0, hc05_tx}, {31'b0, bits[k]});
        @(posedge clk); #1;
      end
    end
    $display("frame %s byte=%02h checked, ended cycle %0d", tag, b, cyc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] rd_a;
    int r;
    int ra;
    int seen_low;

    // Reset state, and a request held during reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {31'b0, hc05_tx}, 32'd1);
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_data_o", data_o, 32'h0);
    valid = 1'b1; addr = 3'h4; strb = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_no_ack", {31'b0, ready}, 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ack", {31'b0, ready}, 32'd1);
    check("post_rst_status", data_o, 32'h04);
    @(posedge clk); #1;
    valid = 1'b0;
    check("post_rst_pulse", {31'b0, ready}, 32'd0);

    // DATA reads as zero; a DATA write without strb[0] is ignored
    bus_xfer(3'h0, 4'h0, 32'h0, rd, r);
    check("rd_data_zero", rd, 32'h0);
    bus_xfer(3'h0, 4'b0010, 32'hAB, rd, r);
    repeat (3) @(posedge clk);
    #1;
    check("nostrb_tx_idle", {31'b0, hc05_tx}, 32'd1);
    bus_xfer(3'h4, 4'h0, 32'h0, rd, r);
    check("nostrb_status", rd, 32'h04);

    // Single byte 0x55: start bit two cycles after ready
    bus_xfer(3'h0, 4'h1, 32'h55, rd, r);
    check("lat_still_idle", {31'b0, hc05_tx}, 32'd1);
    @(posedge clk); #1;
    check("lat_start_cycle", cyc, r + 2);
    check_frame(8'h55, "f55");
    check("f55_idle_after", {31'b0, hc05_tx}, 32'd1);
    bus_xfer(3'h4, 4'h0, 32'h0, rd, r);
    check("f55_status_after", rd, 32'h04);

    // Five back-to-back bytes, frames must chain with no gap
    bus_xfer(3'h0, 4'h1, 32'h01, rd, r);
    fork
      begin
        for (int i = 2; i <= 5; i++) bus_xfer(3'h0, 4'h1, 32'(i), rd_a, ra);
        while (cyc < r + 150) begin
          @(posedge clk); #1;
        end
        bus_xfer(3'h4, 4'h0, 32'h0, rd_a, ra);
        check("burst_mid_status", rd_a, 32'h31);
      end
      begin
        @(posedge clk); #1;
        for (int i = 1; i <= 5; i++) check_frame(8'(i), "burst");
      end
    join
    check("burst_idle_after", {31'b0, hc05_tx}, 32'd1);
    bus_xfer(3'h4, 4'h0, 32'h0, rd, r);
    check("burst_status_after", rd, 32'h04);

    // Overflow, OVF clear, and a write landing on the stop->start pop with the FIFO full
    bus_xfer(3'h0, 4'h1, 32'h11, rd, r);
    fork
      begin
        bus_xfer(3'h0, 4'h1, 32'h22, rd_a, ra);
        bus_xfer(3'h0, 4'h1, 32'h33, rd_a, ra);
        bus_xfer(3'h0, 4'h1, 32'h44, rd_a, ra);
        bus_xfer(3'h0, 4'h1, 32'h55, rd_a, ra);
        bus_xfer(3'h0, 4'h1, 32'h66, rd_a, ra);
        bus_xfer(3'h4, 4'h0, 32'h0, rd_a, ra);
        check("ovf_status", rd_a, 32'h4B);
        bus_xfer(3'h4, 4'h1, 32'h08, rd_a, ra);
        bus_xfer(3'h4, 4'h0, 32'h0, rd_a, ra);
        check("ovf_clr_status", rd_a, 32'h43);
        while (cyc < r + FRAME) begin
          @(posedge clk); #1;
        end
        bus_xfer(3'h0, 4'h1, 32'h77, rd_a, ra);
        check("pop_edge_ack_cycle", ra, r + FRAME + 1);
        bus_xfer(3'h4, 4'h0, 32'h0, rd_a, ra);
        check("pop_edge_status", rd_a, 32'h43);
      end
      begin
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) check_frame(ovf_frames[i], "ovf");
      end
    join
    check("ovf_idle_after", {31'b0, hc05_tx}, 32'd1);
    bus_xfer(3'h4, 4'h0, 32'h0, rd, r);
    check("ovf_status_after", rd, 32'h04);

    // Reset pulse in data bit 3 of 0xA5 aborts the frame for good
    bus_xfer(3'h0, 4'h1, 32'hA5, rd, r);
    while (cyc < r + 45) begin
      @(posedge clk); #1;
    end
    check("abort_bit3_low", {31'b0, hc05_tx}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_tx_high", {31'b0, hc05_tx}, 32'd1);
    bus_xfer(3'h4, 4'h0, 32'h0, rd, r);
    check("abort_status", rd, 32'h04);
    seen_low = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (hc05_tx !== 1'b1) seen_low = 1;
      @(posedge clk); #1;
    end
    check("abort_no_resend", seen_low, 32'd0);

`ifdef BT_TX_PARITY_EN
    // Even parity: 0x07 -> 1, 0x03 -> 0
    bus_xfer(3'h0, 4'h1, 32'h07, rd, r);
    @(posedge clk); #1;
    check_frame(8'h07, "par07");
    bus_xfer(3'h0, 4'h1, 32'h03, rd, r);
    @(posedge clk); #1;
    check_frame(8'h03, "par03");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bluetooth_tx.md
BLUETOOTH_TX -- requirements
Module: bluetooth_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz SHALL be supported.
REQ-002 Parameter BAUD, default 9600, serial bit rate SHALL be supported; DIV = CLK_FREQ/BAUD (integer, >=2).
REQ-003 Parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of 2, 2..16) SHALL be supported.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 valid  input  1  bus request, held high until ready is seen; decoded externally for this block's address window.
REQ-007 strb  input  4  write byte strobes; 4'b0000 = read.
REQ-008 addr  input  3  word offset within block: 0x0 DATA, 0x4 STATUS.
REQ-009 data_i  input  32  write data.
REQ-010 ready  output  1  one-cycle bus acknowledge.
REQ-011 data_o  output  32  read data, valid while ready=1, 32'h0 otherwise.
REQ-012 hc05_tx  output  1  UART serial line to HC-05, idle high, registered.

Function
REQ-013 ready SHALL assert the cycle after valid is first sampled high with ready low, and SHALL deassert the following cycle (one pulse per request).
REQ-014 Register effects SHALL occur in the cycle ready=1, qualified by valid and strb[0].
REQ-015 Write DATA: data_i[7:0] SHALL be pushed into the FIFO if FIFO not full, or if a pop occurs the same cycle.
REQ-016 Write DATA when full with no same-cycle pop: byte SHALL be dropped and sticky OVF set.
REQ-017 Write STATUS with data_i[3]=1 SHALL clear OVF; other STATUS bits are read-only.
REQ-018 Read DATA SHALL return 32'h0; read STATUS SHALL return {24'h0, count[3:0], OVF, EMPTY, FULL, BUSY} in bits [7:0].
REQ-019 BUSY = FSM not IDLE; EMPTY = count==0; FULL = count==FIFO_DEPTH; count = FIFO occupancy.
REQ-020 FSM states IDLE, START, DATA, PARITY, STOP; each non-IDLE bit period lasts exactly DIV clk cycles via a baud counter 0..DIV-1.
REQ-021 IDLE: hc05_tx=1; when FIFO non-empty, pop head into shift register and enter START next cycle.
REQ-022 START: hc05_tx=0; then DATA.
REQ-023 DATA: 8 bits LSB first; after bit 7, PARITY if enabled (REQ-031) else STOP.
REQ-024 STOP: hc05_tx=1 for DIV cycles; at end, if FIFO non-empty pop and enter START directly (no idle gap), else IDLE.
REQ-025 Latency: push into empty FIFO with FSM IDLE SHALL drive hc05_tx low exactly 2 cycles after the ready cycle.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; push and pop in the same cycle SHALL leave count unchanged.
REQ-027 Bus activity SHALL NOT disturb a frame in progress; baud counter runs only outside IDLE and resets to 0 at each bit boundary.

Reset
REQ-028 rst=1 SHALL force: FSM IDLE, hc05_tx=1, ready=0, data_o=0, FIFO empty (pointers/count 0), OVF=0, baud counter 0.
REQ-029 rst asserted mid-frame SHALL abort the frame; hc05_tx=1 the cycle after rst is sampled; discarded bytes are not resent.
REQ-030 A request with valid high during rst SHALL not be acknowledged until after rst deasserts.

Configuration
REQ-031 Macro BT_TX_PARITY_EN defined: PARITY state inserted after DATA, transmitting even parity (XOR of 8 data bits), frame = 11 bit periods.
REQ-032 Macro BT_TX_PARITY_EN undefined: no PARITY state or logic, frame = 10 bit periods (8N1, HC-05 default).

Verification (CLK_FREQ=1000000, BAUD=100000, DIV=10, FIFO_DEPTH=4)
REQ-033 Write DATA 0x55 after reset -> ready pulse 1 cycle; hc05_tx low 2 cycles after ready for 10 cycles, then 1,0,1,0,1,0,1,0 per 10 cycles, stop high 10; frame 100 cycles (110 with parity bit 0).
REQ-034 Five back-to-back DATA writes 0x01..0x05 while idle -> 5 frames with no idle gap between stop and next start; STATUS read mid-stream shows BUSY=1, OVF=0.
REQ-035 Six DATA writes within one frame time -> first popped, four queued, sixth dropped; STATUS = FULL=1, OVF=1, count=4; write STATUS 0x08 -> OVF=0.
REQ-036 Write at the exact cycle of STOP->START pop with FIFO full -> byte accepted, count stays 4, OVF stays 0.
REQ-037 rst pulse during DATA bit 3 of 0xA5 -> hc05_tx=1 next cycle, STATUS=0x04 (EMPTY only), no further frame.
REQ-038 PARITY_EN build, write 0x07 -> parity bit 1; write 0x03 -> parity bit 0.
